// File: rtl/regfile_rename_pkg.sv
// Shared types for the architectural register file and its rename/recovery state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_rename_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int TW        = $clog2(ROB_DEPTH);
    localparam int NREGS     = 32;

    typedef logic [TW-1:0] rob_tag_t;
    typedef logic [4:0]    reg_idx_t;

    localparam rob_tag_t TAG_ONE = rob_tag_t'(1);

    // One history slot per ROB entry: the mapping this entry's rd displaced.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     prev_busy;
        rob_tag_t prev_tag;
    } hist_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } flush_state_t;
endpackage

// File: rtl/regfile_rename_hist_buf.sv
// Rename-history buffer: one slot per ROB tag, indexed read for the recovery walk.
// Latency: writes/clears take effect next cycle; read is combinational.
// Backpressure: none; every request is accepted the cycle it is presented.
module rename_hist_buf
    import regfile_rename_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_idx,
    input  logic          wr_valid,
    input  logic [4:0]    wr_rd,
    input  logic          wr_prev_busy,
    input  logic [TW-1:0] wr_prev_tag,
    input  logic          commit_en,
    input  logic [TW-1:0] commit_tag,
    input  logic          clr_en,
    input  logic [TW-1:0] clr_idx,
    input  logic [TW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [4:0]    rd_rd,
    output logic          rd_prev_busy,
    output logic [TW-1:0] rd_prev_tag
);
    hist_entry_t mem [ROB_DEPTH];

    // Commit scrubs references to the retiring tag, then walk clear, then the new alloc write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (commit_en) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (mem[i].prev_tag == commit_tag) begin
                        mem[i].prev_busy <= 1'b0;
                    end
                end
                mem[commit_tag].valid <= 1'b0;
            end
            if (clr_en) begin
                mem[clr_idx].valid <= 1'b0;
            end
            if (wr_en) begin
                mem[wr_idx] <= '{valid: wr_valid, rd: wr_rd,
                                 prev_busy: wr_prev_busy, prev_tag: wr_prev_tag};
            end
        end
    end

    assign rd_valid     = mem[rd_idx].valid;
    assign rd_rd        = mem[rd_idx].rd;
    assign rd_prev_busy = mem[rd_idx].prev_busy;
    assign rd_prev_tag  = mem[rd_idx].prev_tag;
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with busy/tag rename state and mispredict rollback walk.
// Latency: lookups combinational; commit/alloc visible next cycle; walk one entry per cycle.
// Backpressure: flush_busy holds issue for the whole walk plus one DONE cycle.
module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  logic [4:0]    alloc_rd,
    input  logic [TW-1:0] alloc_tag,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic [TW-1:0] rs1_tag,
    output logic [TW-1:0] rs2_tag,
    input  logic          commit_en,
    input  logic [4:0]    commit_rd,
    input  logic [TW-1:0] commit_tag,
    input  logic [31:0]   commit_data,
    input  logic          flush_start,
    input  logic [TW-1:0] flush_br_tag,
    input  logic [TW-1:0] flush_tail,
    output logic          flush_busy
);
    logic [31:0]      regs [NREGS];
    rob_tag_t         tags [NREGS];
    logic [NREGS-1:0] busy;

    flush_state_t state;
    rob_tag_t     ptr;
    rob_tag_t     stop;

    logic     commit_hit;
    logic     alloc_ok;
    logic     alloc_prev_busy;
    logic     walk_active;
    logic     h_valid;
    reg_idx_t h_rd;
    logic     h_prev_busy;
    rob_tag_t h_prev_tag;
    logic     restore;
    logic     restore_busy;
    rob_tag_t tail_m1;
    rob_tag_t stop_p1;

    assign commit_hit  = commit_en && (commit_rd != 5'd0);
    assign alloc_ok    = alloc && (state == IDLE);
    assign walk_active = (state == WALK);
    assign tail_m1     = flush_tail - TAG_ONE;
    assign stop_p1     = stop + TAG_ONE;
    assign flush_busy  = (state != IDLE);

    // A same-cycle commit of the current producer means the displaced mapping is already retired.
    assign alloc_prev_busy = busy[alloc_rd] &
        ~(commit_hit && (commit_rd == alloc_rd) && (tags[alloc_rd] == commit_tag));

    // Commit in the walk cycle lands first, so a restore must not revive the tag it just retired.
    assign restore      = walk_active && h_valid;
    assign restore_busy = h_prev_busy & ~(commit_hit && (h_prev_tag == commit_tag));

    rename_hist_buf u_hist (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (alloc_ok),
        .wr_idx       (alloc_tag),
        .wr_valid     (alloc_rd != 5'd0),
        .wr_rd        (alloc_rd),
        .wr_prev_busy (alloc_prev_busy),
        .wr_prev_tag  (tags[alloc_rd]),
        .commit_en    (commit_hit),
        .commit_tag   (commit_tag),
        .clr_en       (walk_active),
        .clr_idx      (ptr),
        .rd_idx       (ptr),
        .rd_valid     (h_valid),
        .rd_rd        (h_rd),
        .rd_prev_busy (h_prev_busy),
        .rd_prev_tag  (h_prev_tag)
    );

    // Register/rename update: commit first, then alloc or walk restore overrides the mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (commit_hit) begin
                regs[commit_rd] <= commit_data;
                if (tags[commit_rd] == commit_tag) begin
                    busy[commit_rd] <= 1'b0;
                end
            end
            if (alloc_ok && (alloc_rd != 5'd0)) begin
                busy[alloc_rd] <= 1'b1;
                tags[alloc_rd] <= alloc_tag;
            end
            if (restore) begin
                busy[h_rd] <= restore_busy;
                tags[h_rd] <= h_prev_tag;
            end
        end
    end

    // Recovery walk: youngest entry first, stopping just above the branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            stop  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_start) begin
                        ptr   <= tail_m1;
                        stop  <= flush_br_tag;
                        state <= (tail_m1 == flush_br_tag) ? DONE : WALK;
                    end
                end
                WALK: begin
                    ptr <= ptr - TAG_ONE;
                    if (ptr == stop_p1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Source lookups: x0 is constant zero, a matching same-cycle commit is forwarded.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
        rs1_tag  = tags[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
        end else if (commit_hit && (commit_rd == rs1_addr) && busy[rs1_addr] &&
                     (tags[rs1_addr] == commit_tag)) begin
            rs1_data = commit_data;
            rs1_busy = 1'b0;
        end
    end

    // Second source port, same rules as the first.
    always_comb begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
        rs2_tag  = tags[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
        end else if (commit_hit && (commit_rd == rs2_addr) && busy[rs2_addr] &&
                     (tags[rs2_addr] == commit_tag)) begin
            rs2_data = commit_data;
            rs2_busy = 1'b0;
        end
    end

    // Issue must be held off while the walk owns the rename state.
    assert property (@(posedge clk) disable iff (rst) !(alloc && flush_busy));
endmodule

// File: tb/tb_regfile_rename.sv
// Directed scenarios plus a randomized ROB-order run against an in-flight-list model.
// Latency: checks lookups combinationally and rename state one cycle after each edge.
// Backpressure: stimulus never issues while flush_busy is high.
module tb_regfile_rename;
    import regfile_rename_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          alloc;
    logic [4:0]    alloc_rd;
    logic [TW-1:0] alloc_tag;
    logic [4:0]    rs1_addr, rs2_addr;
    logic [31:0]   rs1_data, rs2_data;
    logic          rs1_busy, rs2_busy;
    logic [TW-1:0] rs1_tag, rs2_tag;
    logic          commit_en;
    logic [4:0]    commit_rd;
    logic [TW-1:0] commit_tag;
    logic [31:0]   commit_data;
    logic          flush_start;
    logic [TW-1:0] flush_br_tag;
    logic [TW-1:0] flush_tail;
    logic          flush_busy;

    regfile_rename dut (
        .clk(clk), .rst(rst), .alloc(alloc), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_data(commit_data), .flush_start(flush_start), .flush_br_tag(flush_br_tag),
        .flush_tail(flush_tail), .flush_busy(flush_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] data; logic busy; rob_tag_t tag; } look_t;
    typedef struct packed { logic [4:0] rd; rob_tag_t tag; } rob_e_t;

    // Reference: in-flight instructions in program order plus committed values.
    rob_e_t      q[$];
    logic [31:0] mregs [32];
    rob_tag_t    tail;
    rob_tag_t    walk_exp [6];

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic chk_ports(input string nm, input look_t e1, input look_t e2);
        chk({nm, ".rs1_data"}, rs1_data, e1.data);
        chk({nm, ".rs1_busy"}, 32'(rs1_busy), 32'(e1.busy));
        if (e1.busy) chk({nm, ".rs1_tag"}, 32'(rs1_tag), 32'(e1.tag));
        chk({nm, ".rs2_data"}, rs2_data, e2.data);
        chk({nm, ".rs2_busy"}, 32'(rs2_busy), 32'(e2.busy));
        if (e2.busy) chk({nm, ".rs2_tag"}, 32'(rs2_tag), 32'(e2.tag));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc = 0; alloc_rd = 0; alloc_tag = 0;
        commit_en = 0; commit_rd = 0; commit_tag = 0; commit_data = 0;
        flush_start = 0; flush_br_tag = 0; flush_tail = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); tick(); rst = 0;
        q.delete(); tail = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    task automatic look(input string nm, input logic [4:0] r, input logic [31:0] d,
                        input logic b, input rob_tag_t t);
        look_t e;
        e.data = d; e.busy = b; e.tag = t;
        rs1_addr = r; rs2_addr = r;
        #1;
        chk_ports(nm, e, e);
    endtask

    task automatic do_alloc(input logic [4:0] rd, input rob_tag_t t);
        idle_inputs(); alloc = 1; alloc_rd = rd; alloc_tag = t; tick(); idle_inputs();
    endtask

    task automatic do_commit(input logic [4:0] rd, input rob_tag_t t, input logic [31:0] d);
        idle_inputs(); commit_en = 1; commit_rd = rd; commit_tag = t; commit_data = d;
        tick(); idle_inputs();
    endtask

    task automatic do_flush_pulse(input rob_tag_t br, input rob_tag_t tl);
        idle_inputs(); flush_start = 1; flush_br_tag = br; flush_tail = tl;
        tick(); idle_inputs();
    endtask

    // Count cycles flush_busy stays high, bounded.
    task automatic wait_flush(output int n);
        n = 0;
        while (flush_busy && n < 40) begin tick(); n++; end
    endtask

    // Branch (no rd) at tag 6, then x20 written by tags 7,0,1,...,5: ROB full.
    task automatic setup_full();
        do_alloc(5'd0, 3'd6);
        for (int k = 0; k < 7; k++) do_alloc(5'd20, rob_tag_t'(7 + k));
    endtask

    // Lookup as seen by issue: youngest surviving producer, or committed value.
    function automatic look_t model_look(input logic [4:0] r, input bit commit_now,
                                         input logic [31:0] cdata);
        look_t e;
        int p;
        e = '0;
        p = -1;
        if (r == 5'd0) return e;
        for (int i = 0; i < q.size(); i++) if (q[i].rd == r) p = i;
        e.data = mregs[r];
        if (p < 0) return e;
        if (commit_now && p == 0) begin e.data = cdata; return e; end
        e.busy = 1'b1;
        e.tag  = q[p].tag;
        return e;
    endfunction

    task automatic sweep_all(input string nm);
        idle_inputs();
        for (int r = 0; r < 32; r += 2) begin
            rs1_addr = 5'(r); rs2_addr = 5'(r + 1);
            #1;
            chk_ports(nm, model_look(5'(r), 1'b0, 32'd0), model_look(5'(r + 1), 1'b0, 32'd0));
            tick();
        end
    endtask

    task automatic rand_flush();
        int b, n, expn;
        rob_tag_t br, d;
        b  = $urandom_range(0, q.size() - 1);
        br = q[b].tag;
        d  = tail - br - TAG_ONE;
        expn = int'(d) + 1;
        do_flush_pulse(br, tail);
        while (q.size() > b + 1) void'(q.pop_back());
        tail = br + TAG_ONE;
        n = 0;
        while (flush_busy && n < 40) begin
            bit c;
            c = (q.size() > 1) && ($urandom_range(0, 1) == 1);
            idle_inputs();
            if (c) begin
                commit_en = 1; commit_rd = q[0].rd; commit_tag = q[0].tag; commit_data = $urandom;
            end
            tick();
            if (c) begin
                if (q[0].rd != 5'd0) mregs[q[0].rd] = commit_data;
                void'(q.pop_front());
            end
            n++;
        end
        idle_inputs();
        chk("rand.walk_cycles", n, expn);
        sweep_all("rand.post_flush");
    endtask

    initial begin
        int n;
        walk_exp[0] = 3'd4; walk_exp[1] = 3'd3; walk_exp[2] = 3'd2;
        walk_exp[3] = 3'd1; walk_exp[4] = 3'd0; walk_exp[5] = 3'd7;
        rs1_addr = 0; rs2_addr = 0;
        do_reset();
        tick();

        // Reset values and plain commit.
        look("reset_x5", 5'd5, 32'd0, 1'b0, 3'd0);
        chk("reset_flush_busy", 32'(flush_busy), 32'd0);
        do_commit(5'd5, 3'd2, 32'hDEADBEEF);
        look("commit_x5", 5'd5, 32'hDEADBEEF, 1'b0, 3'd0);
        do_commit(5'd0, 3'd3, 32'h12345678);
        look("x0_zero", 5'd0, 32'd0, 1'b0, 3'd0);

        // Younger producer keeps ownership when the older one commits.
        do_reset();
        do_alloc(5'd3, 3'd1);
        do_alloc(5'd3, 3'd4);
        do_commit(5'd3, 3'd1, 32'h11);
        look("x3_older_commit", 5'd3, 32'h11, 1'b1, 3'd4);
        do_commit(5'd3, 3'd4, 32'h22);
        look("x3_younger_commit", 5'd3, 32'h22, 1'b0, 3'd0);
        idle_inputs(); alloc = 1; alloc_rd = 5'd10; alloc_tag = 3'd5;
        look("alloc_not_forwarded", 5'd10, 32'd0, 1'b0, 3'd0);
        tick(); idle_inputs();
        look("alloc_visible", 5'd10, 32'd0, 1'b1, 3'd5);

        // Same-cycle commit forwarding.
        do_alloc(5'd7, 3'd6);
        idle_inputs(); commit_en = 1; commit_rd = 5'd7; commit_tag = 3'd6; commit_data = 32'hAB;
        look("commit_forward", 5'd7, 32'hAB, 1'b0, 3'd0);
        tick(); idle_inputs();

        // Mispredict restore over two younger entries.
        do_reset();
        do_alloc(5'd8, 3'd0);
        do_alloc(5'd0, 3'd1);
        do_alloc(5'd8, 3'd2);
        do_alloc(5'd9, 3'd3);
        do_flush_pulse(3'd1, 3'd4);
        wait_flush(n);
        chk("restore_cycles", n, 3);
        look("restore_x8", 5'd8, 32'd0, 1'b1, 3'd0);
        look("restore_x9", 5'd9, 32'd0, 1'b0, 3'd0);

        // Commit during the walk must not be undone by the restore.
        do_reset();
        do_alloc(5'd4, 3'd0);
        do_alloc(5'd0, 3'd1);
        do_alloc(5'd4, 3'd2);
        do_flush_pulse(3'd1, 3'd3);
        chk("stale_in_walk", 32'(flush_busy), 32'd1);
        do_commit(5'd4, 3'd0, 32'h5);
        wait_flush(n);
        chk("stale_cycles", n + 1, 2);
        look("stale_x4", 5'd4, 32'h5, 1'b0, 3'd0);

        // Full ROB with wrap: restore order observed one step at a time.
        do_reset();
        setup_full();
        look("full_pre", 5'd20, 32'd0, 1'b1, 3'd5);
        do_flush_pulse(3'd6, 3'd6);
        for (int i = 0; i < 7; i++) begin
            chk("full_walk_busy", 32'(flush_busy), 32'd1);
            tick();
            if (i < 6) look("full_step", 5'd20, 32'd0, 1'b1, walk_exp[i]);
            else       look("full_last", 5'd20, 32'd0, 1'b0, 3'd0);
        end
        chk("full_done_busy", 32'(flush_busy), 32'd1);
        tick();
        chk("full_idle", 32'(flush_busy), 32'd0);

        // Reset in the middle of a walk.
        do_reset();
        setup_full();
        do_flush_pulse(3'd6, 3'd6);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_walk_flush_busy", 32'(flush_busy), 32'd0);
        for (int r = 1; r < 32; r++) look("rst_walk_busy", 5'(r), 32'd0, 1'b0, 3'd0);

        // Randomized program-order traffic with occasional mispredicts.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit dc, da, df;
            look_t e1, e2;
            dc = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            da = ((q.size() - int'(dc)) < ROB_DEPTH) && ($urandom_range(0, 3) != 0);
            df = (q.size() > 0) && ($urandom_range(0, 24) == 0);
            if (df) begin
                rand_flush();
            end else begin
                idle_inputs();
                if (dc) begin
                    commit_en = 1; commit_rd = q[0].rd; commit_tag = q[0].tag; commit_data = $urandom;
                end
                if (da) begin
                    alloc = 1; alloc_rd = 5'($urandom_range(0, 7)); alloc_tag = tail;
                end
                rs1_addr = 5'($urandom_range(0, 7));
                rs2_addr = 5'($urandom_range(0, 31));
                e1 = model_look(rs1_addr, dc, commit_data);
                e2 = model_look(rs2_addr, dc, commit_data);
                #1;
                chk_ports("rand", e1, e2);
                tick();
                if (dc) begin
                    if (q[0].rd != 5'd0) mregs[q[0].rd] = commit_data;
                    void'(q.pop_front());
                end
                if (da) begin
                    rob_e_t ne;
                    ne.rd = alloc_rd; ne.tag = tail;
                    q.push_back(ne);
                    tail = tail + TAG_ONE;
                end
            end
        end
        idle_inputs();
        sweep_all("rand.final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file plus per-register rename state (busy bit, ROB tag), sitting directly downstream of the ROB commit port and upstream of the reservation stations.
- Issue-side lookups return either committed data or the ROB tag of the pending producer.
- Commits write ROB-supplied data.
- On a branch mispredict it walks an 8-entry rename-history buffer youngest-first, restoring each overwritten mapping, so rename state matches the surviving instructions.

Parameters:
- ROB_DEPTH, 8, ROB entries; tag width TW = $clog2(ROB_DEPTH) = 3.
- NREGS, 32, architectural registers; x0 hardwired zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc  in  1  issue of an instruction writing rd (ROB load, non-store, non-branch)
- alloc_rd  in  5  destination register
- alloc_tag  in  TW  ROB entry allocated (ROB curr_ptr)
- rs1_addr, rs2_addr  in  5 each  source lookups
- rs1_data, rs2_data  out  32 each  committed register value
- rs1_busy, rs2_busy  out  1 each  value pending in ROB
- rs1_tag, rs2_tag  out  TW each  producer tag when busy
- commit_en  in  1  ROB regfile_load
- commit_rd  in  5  ROB rd_commit
- commit_tag  in  TW  ROB head_ptr
- commit_data  in  32  value from CDB/d-cache mux
- flush_start  in  1  one-cycle pulse, mispredict detected
- flush_br_tag  in  TW  ROB index of the mispredicted branch
- flush_tail  in  TW  ROB curr_ptr at mispredict (first unallocated entry)
- flush_busy  out  1  walk in progress; ROB and IQ hold issue

Behaviour:
- Reset:
  - all regs 0, busy 0, tag 0.
  - History valid bits 0.
  - State IDLE, flush_busy 0.
  - Lookup outputs are combinational; after reset they read 0/0/0.
- Lookup is combinational with zero latency.
  - x0 always returns data 0, busy 0, tag 0.
  - Same-cycle commit to the looked-up register forwards: if commit_en, commit_rd==rsX, and the register is busy with tag==commit_tag, output data=commit_data and busy=0.
  - Same-cycle alloc is NOT forwarded; the issuing instruction sees the older mapping.
- Alloc, with alloc_rd != 0 and state IDLE:
  - hist[alloc_tag] <= {valid=1, rd, prev_busy=busy[rd], prev_tag=tag[rd]}.
  - busy[rd] <= 1, tag[rd] <= alloc_tag.
  - alloc with rd=0 writes hist valid=0.
  - alloc asserted while flush_busy is an illegal stimulus (assertion); it is ignored.
- Commit, with commit_rd != 0:
  - regs[rd] <= commit_data.
  - busy[rd] <= 0 only if tag[rd]==commit_tag; otherwise a younger producer owns rd and busy stays set.
  - Every hist entry with prev_busy=1 and prev_tag==commit_tag clears prev_busy, so a later restore never resurrects a committed tag.
  - hist[commit_tag].valid <= 0.
- Alloc and commit in the same cycle on the same rd:
  - alloc mapping wins (busy=1, tag=alloc_tag).
  - hist records prev_busy computed after the commit clear, i.e. 0 if the committing tag matched.
- Flush FSM:
  - IDLE -> WALK on flush_start. Latch ptr = flush_tail-1 and stop = flush_br_tag (mod ROB_DEPTH).
  - If flush_tail-1 == flush_br_tag, there is nothing younger: go to DONE immediately.
  - WALK, one entry per cycle. If hist[ptr].valid: busy[rd] <= prev_busy, tag[rd] <= prev_tag, hist[ptr].valid <= 0.
  - ptr decrements with wrap (0 -> 7). When ptr == stop+1 has been processed, go to DONE.
  - DONE: one cycle, then IDLE.
  - flush_busy = 1 in WALK and DONE.
  - Walk latency = (flush_tail - flush_br_tag - 1) mod 8 cycles, plus 1 for DONE.
  - A full ROB (tail == branch) walks 7 entries.
  - The branch entry itself is never restored.
- Commit during WALK is legal (ROB may still retire older work) and is applied before that cycle's restore.
- flush_start while not IDLE is ignored.
- rst mid-walk returns everything to its reset values in the next cycle.

Decomposition:
- Shared package (rv32i_types / tomasula_types): rob_tag_t (logic [TW-1:0]), hist_entry_t struct {valid, rd, prev_busy, prev_tag}, flush FSM enum {IDLE, WALK, DONE}.
- One natural sub-module: rename_hist_buf (8-entry history storage, prev_tag CAM-clear on commit, indexed read for the walk).
- Register array and lookup logic stay in regfile_rename.

Test Plan:
- Reset, then read x5 -> data 0, busy 0. Commit x5=0xDEADBEEF tag 2 (not busy) -> x5 data 0xDEADBEEF, busy 0.
- Alloc x3 tag 1, then alloc x3 tag 4, then commit x3 tag 1 data 0x11 -> x3 busy 1, tag 4, data 0x11. Commit tag 4 data 0x22 -> busy 0, data 0x22.
- Same-cycle forward: x7 busy with tag 6; commit x7 tag 6 data 0xAB while looking up rs1=x7 -> rs1_data 0xAB, rs1_busy 0 in that cycle.
- Mispredict restore: x8 busy tag 0. Branch at tag 1. Alloc x8 tag 2, alloc x9 tag 3. flush_start with br=1, tail=4 -> flush_busy high 3 cycles. Afterwards x8 busy, tag 0; x9 busy 0.
- Stale-restore guard: x4 alloc tag 0, branch tag 1, alloc x4 tag 2. Commit tag 0 data 0x5 during WALK -> after flush x4 busy 0, data 0x5.
- Wrap and full: branch at tag 6, allocs at tags 7,0,1,2,3,4,5, flush with tail=6 -> 7 walk cycles, all seven entries restored in order 5,4,3,2,1,0,7. rst asserted mid-walk instead -> flush_busy 0 and all busy bits 0 next cycle.
